// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC update selector, fetch FSM states and the
// next-PC arithmetic used by both the fetch unit and the branch logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      PC_HOLD  = 2'b00,
      PC_PLUS4 = 2'b01,
      PC_JUMP  = 2'b10,
      PC_IN    = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } fetch_state_e;

   // Next PC for a given selector; word offset is scaled to bytes, all modulo 2^32
   function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                           input pc_sel_e     sel,
                                           input logic [31:0] k,
                                           input logic [31:0] pc_in);
      logic [31:0] res;
      case (sel)
         PC_HOLD:  res = pc;
         PC_PLUS4: res = pc + 32'd4;
         PC_JUMP:  res = pc + (k << 2);
         PC_IN:    res = pc_in;
         default:  res = pc;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register with next-PC selection. pc_next_o exposes the
// value that will be committed so a same-cycle fetch can use it.
module program_counter
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_en_i,
   input  logic [1:0]  pc_sel_i,
   input  logic [31:0] pc_k_i,
   input  logic [31:0] pc_in_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_next_o,
   output logic [31:0] pc_plus4_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Select the next PC; only a committed load changes it
   always_comb begin
      pc_d = pc_q;
      if (load_en_i) begin
         pc_d = next_pc(pc_q, pc_sel_e'(pc_sel_i), pc_k_i, pc_in_i);
      end else begin
         pc_d = pc_q;
      end
   end

   // PC register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_next_o  = pc_d;
   assign pc_plus4_o = pc_q + 32'd4;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/REQ/DONE handshake with instruction memory,
// ack timeout, misalignment detection, instruction register and PC.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] pc_k,
   input  logic [31:0] pc_in,
   input  logic        pc_load,
   input  logic        fetch_start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IR,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        busy,
   output logic        fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   fetch_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ir_q, ir_d;
   logic             err_q, err_d;
   logic [31:0]      pc_next_s;
   logic             idle_s;
   logic             aligned_s;
   logic             timeout_s;

   assign idle_s    = (state_q == ST_IDLE);
   // Alignment is judged on the PC the fetch will actually use
   assign aligned_s = (pc_next_s[1:0] == 2'b00);
   assign timeout_s = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

   program_counter #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i      (clock),
      .rst_ni     (reset),
      .load_en_i  (pc_load && idle_s),
      .pc_sel_i   (pc_sel),
      .pc_k_i     (pc_k),
      .pc_in_i    (pc_in),
      .pc_o       (pc),
      .pc_next_o  (pc_next_s),
      .pc_plus4_o (pc_plus4)
   );

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: ack wins over timeout in the final wait cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_start && aligned_s) state_d = ST_REQ;
            else                          state_d = ST_IDLE;
         end
         ST_REQ: begin
            if (imem_ack)       state_d = ST_DONE;
            else if (timeout_s) state_d = ST_IDLE;
            else                state_d = ST_REQ;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the registered state
   always_comb begin
      imem_req  = (state_q == ST_REQ);
      imem_addr = 32'h0000_0000;
      if (state_q == ST_REQ) imem_addr = pc;
      else                   imem_addr = 32'h0000_0000;
      ir_valid  = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
   end

   // Wait counter, instruction register and sticky error next values
   always_comb begin
      cnt_d = {CNT_W{1'b0}};
      ir_d  = ir_q;
      err_d = err_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_start) err_d = !aligned_s;
            else             err_d = err_q;
         end
         ST_REQ: begin
            if (imem_ack) begin
               ir_d = imem_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (timeout_s) err_d = 1'b1;
               else           err_d = err_q;
            end
         end
         ST_DONE: cnt_d = {CNT_W{1'b0}};
         default: cnt_d = {CNT_W{1'b0}};
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= {CNT_W{1'b0}};
         ir_q  <= 32'h0000_0000;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ir_q  <= ir_d;
         err_q <= err_d;
      end
   end

   assign IR        = ir_q;
   assign fetch_err = err_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL be the maximum number of cycles to wait for imem_ack before aborting.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc_sel  input  2  SHALL select the PC update: 00 HOLD, 01 PLUS4, 10 JUMP, 11 IN.
REQ-006 pc_k  input  32  SHALL be the sign-extended branch offset in words, produced by the control unit's k output.
REQ-007 pc_in  input  32  SHALL be the register-sourced target for pc_sel IN (BR).
REQ-008 pc_load  input  1  SHALL be the strobe that commits a PC update.
REQ-009 fetch_start  input  1  SHALL be the request to fetch the instruction at the current PC.
REQ-010 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-011 imem_addr  output  32  SHALL be the instruction-memory byte address.
REQ-012 imem_ack  input  1  SHALL indicate that imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  input  32  SHALL carry the instruction word.
REQ-014 IR  output  32  SHALL be the instruction register feeding the control unit.
REQ-015 ir_valid  output  1  SHALL be a one-cycle pulse after IR loads.
REQ-016 pc  output  32  SHALL be the current PC.
REQ-017 pc_plus4  output  32  SHALL be pc+4, combinational, used as the BL link value.
REQ-018 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-019 fetch_err  output  1  SHALL be the sticky error flag for misalignment or timeout.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, REQ, and DONE.
REQ-021 In IDLE, fetch_start with pc[1:0]==00 SHALL transition the FSM to REQ and clear fetch_err.
REQ-022 In IDLE, fetch_start with pc[1:0]!=00 SHALL keep the FSM in IDLE, set fetch_err, and issue no request.
REQ-023 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until ack or timeout.
REQ-024 In REQ, imem_ack SHALL load IR from imem_rdata at that edge and transition the FSM to DONE.
REQ-025 In DONE, ir_valid SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-026 The wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT, the block SHALL set fetch_err, drop imem_req, leave IR unchanged, and return to IDLE.
REQ-028 Minimum latency SHALL be 2 edges from fetch_start to ir_valid=1 when ack arrives in the first REQ cycle.
REQ-029 With pc_load=1 in IDLE, the PC SHALL become: HOLD pc; PLUS4 pc+4; JUMP pc+(pc_k<<2); IN pc_in.
REQ-030 All PC arithmetic SHALL be modulo 2^32 (wrap-around), e.g. 32'hFFFF_FFFC + 4 = 0.
REQ-031 pc_load and fetch_start asserted in the same IDLE cycle SHALL commit the PC first; the fetch SHALL use the updated PC.
REQ-032 pc_load and fetch_start SHALL be ignored while busy=1.
REQ-033 imem_ack outside REQ SHALL be ignored.
REQ-034 imem_addr SHALL be 0 whenever imem_req is 0.

Reset
REQ-035 On reset low, the block SHALL asynchronously set pc=RESET_PC, IR=0, ir_valid=0, imem_req=0, fetch_err=0, counter=0, and state=IDLE.
REQ-036 Reset asserted mid-fetch SHALL drop imem_req immediately, and the block SHALL issue no ir_valid for the aborted fetch.
REQ-037 Operation SHALL resume on the first rising clock edge after reset is released.

Structure
REQ-038 The pc_sel encodings (HOLD/PLUS4/JUMP/IN) and the FSM state encoding SHALL reside in shared package cpu_pkg, which the control unit's branch logic also uses.
REQ-039 PC register and next-PC selection SHALL be a single sub-module, program_counter; the FSM, counter, and IR SHALL reside in instruction_fetch.

Verification
REQ-040 Reset release, fetch_start, ack in first REQ cycle with rdata=32'hB500_0002 -> imem_addr=0, IR=32'hB500_0002, ir_valid one cycle at the 2nd edge, pc=0.
REQ-041 pc=32'h100, pc_sel=JUMP, pc_k=-2, pc_load -> pc=32'hF8; a subsequent pc_sel=PLUS4 load with pc=32'hFFFF_FFFC -> pc=0.
REQ-042 pc_load (IN, pc_in=32'h200) and fetch_start in the same cycle -> imem_addr=32'h200 in REQ.
REQ-043 Ack withheld for 15 REQ cycles -> fetch_err=1, imem_req=0, IR unchanged, state=IDLE; the next fetch_start clears fetch_err.
REQ-044 pc_in=32'h202, pc_sel=IN load, then fetch_start -> fetch_err=1, imem_req never asserted.
REQ-045 Reset pulsed low during REQ -> imem_req=0 immediately, pc=RESET_PC, and no ir_valid afterward.
